ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB-lite memory slave sitting directly downstream of ahb_master.
- Consumes the master's address/control/write-data buses; returns Hready_out, Hresp and Hrdata.
- Word-organised RAM with byte/halfword/word access and a configurable number of wait states.
- Two-cycle ERROR response for illegal accesses; this is the standard target for the master bench.

Parameters:
- ADDR_W, 6, word-index bits; depth = 2**ADDR_W words (byte address range 0 to 4*2**ADDR_W-1).
- WAIT_STATES, 1, data-phase wait cycles inserted before OKAY completion (0..15).

Ports:
- Hclk  in  1  clock, rising edge.
- Hresetn  in  1  reset, asynchronous assert, active-low.
- Hsel  in  1  slave select from decoder.
- Haddr  in  32  byte address.
- Hwrite  in  1  1=write, 0=read.
- Hsize  in  3  000 byte, 001 half, 010 word.
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hready  in  1  bus ready/valid from master; an address phase is accepted only when it is high.
- Hwdata  in  32  write data, valid in the data phase.
- Hready_out  out  1  transfer complete.
- Hresp  out  1  0 OKAY, 1 ERROR.
- Hrdata  out  32  read data, valid when Hready_out=1 and Hresp=0 on a read.

Behaviour:
- Reset (Hresetn=0, asynchronous): state IDLE, Hready_out=1, Hresp=0, Hrdata=0, wait counter=0, captured address/control cleared. RAM contents are not reset.
- Address-phase accept: on a rising edge with Hsel & Hready & Htrans[1] & Hready_out. The slave captures Haddr, Hwrite and Hsize, then checks legality.
- Illegal access, any of:
  - Haddr[31:ADDR_W+2] != 0
  - Hsize > 010
  - misaligned: half with Haddr[0]=1, or word with Haddr[1:0]!=0
- IDLE or BUSY transfers, or Hsel=0: no data phase; Hready_out=1, Hresp=0 (zero-wait OKAY).
- State machine:
  - IDLE: legal accept -> WAIT if WAIT_STATES>0, else RESP. Illegal accept -> ERR1.
  - WAIT: Hready_out=0, Hresp=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 -> RESP.
  - RESP: Hready_out=1, Hresp=0. A write commits Hwdata to RAM at the end of this cycle. A read drives Hrdata in this cycle. A new accept in the same cycle (back-to-back pipelining) transitions as from IDLE; otherwise -> IDLE.
  - ERR1: Hready_out=0, Hresp=1; RAM untouched -> ERR2.
  - ERR2: Hready_out=1, Hresp=1. A new accept is allowed as in RESP; otherwise -> IDLE.
- Byte lanes are little-endian, selected by Haddr[1:0]:
  - byte write: only lane Haddr[1:0] is updated, from Hwdata[8*lane+7:8*lane].
  - half write: lanes {2*Haddr[1], 2*Haddr[1]+1}.
  - word write: all four lanes.
- Reads return the full 32-bit word; Hrdata holds its last value outside read RESP cycles.
- Read directly after a write to the same word: the read's RESP cycle returns the newly written data. The write commits before the read's data phase because the read data phase follows the write's RESP.
- Hwdata, Haddr, Hwrite and Hsize are ignored in WAIT and ERR1. Only the captured copies are used.
- Reset asserted mid-transfer: the transfer is abandoned immediately, no RAM write occurs, and outputs go to reset values.
- Address decode uses only bits [ADDR_W+1:2] for indexing; higher bits must be zero (see illegal conditions).

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - slave state encoding (IDLE, WAIT, RESP, ERR1, ERR2)
- One sub-module, ahb_slave_ram: 2**ADDR_W x 32 storage with a 4-bit byte-enable write port and an asynchronous read port.
- The FSM, legality check and lane logic stay in ahb_slave_mem.

Test Plan:
- Reset: hold Hresetn=0 for 3 cycles, release -> Hready_out=1, Hresp=0, Hrdata=0.
- Word write then read, WAIT_STATES=1:
  - stimulus: NONSEQ write Haddr=0x10, Hsize=010, Hwdata=0xDEADBEEF; then NONSEQ read of 0x10.
  - response: each data phase shows 1 cycle Hready_out=0 then 1 cycle OKAY; read returns 0xDEADBEEF.
- Byte and half writes on top of that word:
  - stimulus: byte write Haddr=0x11, Hwdata=0x0000AA00; half write Haddr=0x12, Hwdata=0x12340000.
  - response: reading 0x10 returns 0x1234AAEF.
- Errors:
  - Haddr=0x400 (ADDR_W=6) -> 2-cycle ERROR: (Hready_out=0, Hresp=1) then (1, 1); the word at index 0 is unchanged.
  - word access to Haddr=0x13 -> same ERROR sequence.
- Back-to-back, WAIT_STATES=0: writes to 0x0, 0x4, 0x8 (0x11111111, 0x22222222, 0x33333333) accepted on consecutive cycles -> Hready_out stays 1; readback is correct.
- Mid-transfer reset: assert Hresetn low during WAIT of a write to 0x20 (with 0x20 preloaded to 0x5A5A5A5A) -> outputs return to reset values immediately; a later read of 0x20 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and helpers for the memory slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian byte-lane enables for a legal access of the given size.
    function automatic logic [3:0] byteEnable(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word-organised storage with byte-enable write and asynchronous read.
module ahb_slave_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // Update only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory slave: accept/legality check, wait-state FSM, lane logic.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hsel,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [1:0]  Htrans,
    input  logic        Hready,
    input  logic [31:0] Hwdata,
    output logic        Hready_out,
    output logic        Hresp,
    output logic [31:0] Hrdata
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [31:0]       hrdata_q;

    logic        accept;
    logic        legal;
    logic        ramWe;
    logic        readPhase;
    logic [31:0] ramRdata;
    logic        unusedTrans;

    assign unusedTrans = Htrans[0];

    assign accept = Hsel & Hready & Htrans[1] & Hready_out;

    assign legal = ((Haddr >> (ADDR_W + 2)) == 32'd0)
                 && (Hsize <= HSIZE_WORD)
                 && !((Hsize == HSIZE_HALF) && Haddr[0])
                 && !((Hsize == HSIZE_WORD) && (Haddr[1:0] != 2'b00));

    // Next-state and counter logic; RESP and ERR2 may take a pipelined accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and captured address/control registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= Haddr[ADDR_W+1:0];
                write_q <= Hwrite;
                size_q  <= Hsize;
            end
        end
    end

    assign Hready_out = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign Hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    assign ramWe     = (state_q == ST_RESP) && write_q;
    assign readPhase = (state_q == ST_RESP) && !write_q;

    ahb_slave_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (Hclk),
        .we_i    (ramWe),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .be_i    (byteEnable(size_q, addr_q[1:0])),
        .wdata_i (Hwdata),
        .rdata_o (ramRdata)
    );

    // Read data is live during a read RESP cycle and held afterwards.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hrdata_q <= 32'd0;
        end else if (readPhase) begin
            hrdata_q <= ramRdata;
        end
    end

    assign Hrdata = readPhase ? ramRdata : hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one slave with a wait state, one with none.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        sel1, sel0;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [1:0]  Htrans;
    logic        Hready;
    logic [31:0] Hwdata;
    logic        ro1, rs1, ro0, rs0;
    logic [31:0] rd1, rd0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model  [2][64];
    logic [31:0] lastRd [2];

    always #5 Hclk = ~Hclk;

    ahb_slave_mem #(.ADDR_W(6), .WAIT_STATES(1)) u_dut1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel1), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hsize(Hsize), .Htrans(Htrans), .Hready(Hready), .Hwdata(Hwdata),
        .Hready_out(ro1), .Hresp(rs1), .Hrdata(rd1)
    );

    ahb_slave_mem #(.ADDR_W(6), .WAIT_STATES(0)) u_dut0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel(sel0), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hsize(Hsize), .Htrans(Htrans), .Hready(Hready), .Hwdata(Hwdata),
        .Hready_out(ro0), .Hresp(rs0), .Hrdata(rd0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit isLegal(input logic [31:0] addr, input logic [2:0] size);
        if (addr >= 32'd256) return 1'b0;
        if (size > 3'd2) return 1'b0;
        return (addr % (32'd1 << size)) == 0;
    endfunction

    function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] res;
        int first, count;
        res   = old;
        first = int'(addr % 4);
        count = 1 << size;
        for (int b = first; b < first + count; b++) res[8*b +: 8] = wdata[8*b +: 8];
        return res;
    endfunction

    function automatic logic obsReady(input bit inst);
        return inst ? ro1 : ro0;
    endfunction

    function automatic logic obsResp(input bit inst);
        return inst ? rs1 : rs0;
    endfunction

    function automatic logic [31:0] obsData(input bit inst);
        return inst ? rd1 : rd0;
    endfunction

    task automatic step();
        @(posedge Hclk);
        @(negedge Hclk);
    endtask

    // One complete non-pipelined transfer, called at a falling edge with the slave idle.
    task automatic applyStimulus(input bit inst, input bit wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata, input string tag);
        int ws;
        bit legal;
        logic [31:0] exp;
        ws    = inst ? 1 : 0;
        legal = isLegal(addr, size);
        sel1 = inst; sel0 = !inst;
        Haddr = addr; Hwrite = wr; Hsize = size; Htrans = HTRANS_NONSEQ; Hready = 1'b1;
        step();
        sel1 = 1'b0; sel0 = 1'b0; Htrans = HTRANS_IDLE; Hwdata = wdata;
        Haddr = $urandom; Hwrite = 1'($urandom); Hsize = 3'($urandom);
        if (!legal) begin
            checkOutput({tag, "_err1_ready"}, 32'(obsReady(inst)), 32'd0);
            checkOutput({tag, "_err1_resp"}, 32'(obsResp(inst)), 32'd1);
            step();
            checkOutput({tag, "_err2_ready"}, 32'(obsReady(inst)), 32'd1);
            checkOutput({tag, "_err2_resp"}, 32'(obsResp(inst)), 32'd1);
            checkOutput({tag, "_err_hold"}, obsData(inst), lastRd[inst]);
            step();
        end else begin
            for (int w = 0; w < ws; w++) begin
                checkOutput({tag, "_wait_ready"}, 32'(obsReady(inst)), 32'd0);
                checkOutput({tag, "_wait_resp"}, 32'(obsResp(inst)), 32'd0);
                step();
            end
            checkOutput({tag, "_okay_ready"}, 32'(obsReady(inst)), 32'd1);
            checkOutput({tag, "_okay_resp"}, 32'(obsResp(inst)), 32'd0);
            if (wr) begin
                model[inst][addr[7:2]] = mergeWrite(model[inst][addr[7:2]], wdata, addr, size);
                checkOutput({tag, "_wr_hold"}, obsData(inst), lastRd[inst]);
            end else begin
                exp = model[inst][addr[7:2]];
                checkOutput({tag, "_rdata"}, obsData(inst), exp);
                lastRd[inst] = exp;
            end
            step();
        end
    endtask

    initial begin
        Hresetn = 1'b0; sel1 = 1'b0; sel0 = 1'b0; Haddr = '0; Hwrite = 1'b0;
        Hsize = HSIZE_WORD; Htrans = HTRANS_IDLE; Hready = 1'b1; Hwdata = '0;
        lastRd[0] = 32'd0; lastRd[1] = 32'd0;

        // Reset held for three cycles, released away from the clock edge.
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1;
        checkOutput("rst_ready1", 32'(ro1), 32'd1);
        checkOutput("rst_resp1", 32'(rs1), 32'd0);
        checkOutput("rst_rdata1", rd1, 32'd0);
        checkOutput("rst_ready0", 32'(ro0), 32'd1);
        checkOutput("rst_resp0", 32'(rs0), 32'd0);
        checkOutput("rst_rdata0", rd0, 32'd0);
        @(negedge Hclk);

        // Give every word of both memories a known value.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i * 4), HSIZE_WORD, $urandom, "fill1");
            applyStimulus(1'b0, 1'b1, 32'(i * 4), HSIZE_WORD, $urandom, "fill0");
        end

        // Word write/read with one wait state, then sub-word writes on top.
        applyStimulus(1'b1, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, "w10");
        applyStimulus(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r10");
        checkOutput("r10_const", rd1, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 32'h11, HSIZE_BYTE, 32'h0000AA00, "wb11");
        applyStimulus(1'b1, 1'b1, 32'h12, HSIZE_HALF, 32'h12340000, "wh12");
        applyStimulus(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r10b");
        checkOutput("r10b_const", rd1, 32'h1234AAEF);

        // Illegal accesses leave memory untouched.
        applyStimulus(1'b1, 1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, "w00");
        applyStimulus(1'b1, 1'b1, 32'h400, HSIZE_WORD, 32'hFFFFFFFF, "e400");
        applyStimulus(1'b1, 1'b0, 32'h0, HSIZE_WORD, 32'h0, "r00");
        checkOutput("r00_const", rd1, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b1, 32'h13, HSIZE_WORD, 32'hFFFFFFFF, "e13");
        applyStimulus(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r10c");
        checkOutput("r10c_const", rd1, 32'h1234AAEF);

        // Back-to-back writes into the zero-wait slave.
        sel0 = 1'b1; Hwrite = 1'b1; Hsize = HSIZE_WORD; Htrans = HTRANS_NONSEQ; Haddr = 32'h0;
        step();
        Hwdata = 32'h11111111; Haddr = 32'h4;
        checkOutput("b2b_ready_a", 32'(ro0), 32'd1);
        step();
        Hwdata = 32'h22222222; Haddr = 32'h8;
        checkOutput("b2b_ready_b", 32'(ro0), 32'd1);
        step();
        Hwdata = 32'h33333333; Htrans = HTRANS_IDLE; sel0 = 1'b0;
        checkOutput("b2b_ready_c", 32'(ro0), 32'd1);
        checkOutput("b2b_resp_c", 32'(rs0), 32'd0);
        step();
        model[0][0] = 32'h11111111; model[0][1] = 32'h22222222; model[0][2] = 32'h33333333;
        applyStimulus(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0, "b2b_r0");
        applyStimulus(1'b0, 1'b0, 32'h4, HSIZE_WORD, 32'h0, "b2b_r4");
        applyStimulus(1'b0, 1'b0, 32'h8, HSIZE_WORD, 32'h0, "b2b_r8");
        checkOutput("b2b_r8_const", rd0, 32'h33333333);

        // Reset during the wait state of a write abandons it.
        applyStimulus(1'b1, 1'b1, 32'h20, HSIZE_WORD, 32'h5A5A5A5A, "pre20");
        applyStimulus(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r10d");
        sel1 = 1'b1; Haddr = 32'h20; Hwrite = 1'b1; Hsize = HSIZE_WORD; Htrans = HTRANS_NONSEQ;
        step();
        sel1 = 1'b0; Htrans = HTRANS_IDLE; Hwdata = 32'hFFFFFFFF;
        checkOutput("mid_wait_ready", 32'(ro1), 32'd0);
        #2 Hresetn = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 32'(ro1), 32'd1);
        checkOutput("mid_rst_resp", 32'(rs1), 32'd0);
        checkOutput("mid_rst_rdata", rd1, 32'd0);
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        lastRd[0] = 32'd0; lastRd[1] = 32'd0;
        @(negedge Hclk);
        applyStimulus(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h0, "r20");
        checkOutput("r20_const", rd1, 32'h5A5A5A5A);

        // Randomized mix of legal, misaligned, oversize and out-of-range accesses.
        for (int n = 0; n < 80; n++) begin
            bit inst, wr;
            int r;
            logic [31:0] addr;
            logic [2:0] size;
            inst = 1'($urandom);
            wr   = 1'($urandom);
            r    = $urandom_range(0, 7);
            addr = 32'($urandom_range(0, 255));
            size = 3'($urandom_range(0, 2));
            if (r == 5) size = 3'($urandom_range(3, 7));
            if (r == 6) addr = 32'($urandom_range(256, 4095));
            if (r == 7) addr = $urandom;
            applyStimulus(inst, wr, addr, size, $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
